// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-master data memory arbiter.
package mem_arb_pkg;

   localparam int DATA_WIDTH = 16;
   localparam int ADDR_WIDTH = 6;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      RESP  = 2'd2
   } state_e;

   localparam logic GNT_CPU = 1'b0;
   localparam logic GNT_AUX = 1'b1;

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester and memory-side signals of the arbiter, grouped by direction.
interface mem_arbiter_if;
   import mem_arb_pkg::*;

   logic                  cpu_req;
   logic                  cpu_we;
   logic [ADDR_WIDTH-1:0] cpu_addr;
   logic [DATA_WIDTH-1:0] cpu_wdata;
   logic                  cpu_ack;
   logic [DATA_WIDTH-1:0] cpu_rdata;

   logic                  aux_req;
   logic                  aux_we;
   logic [ADDR_WIDTH-1:0] aux_addr;
   logic [DATA_WIDTH-1:0] aux_wdata;
   logic                  aux_ack;
   logic [DATA_WIDTH-1:0] aux_rdata;

   logic [ADDR_WIDTH-1:0] mem_addr;
   logic                  mem_we;
   logic [DATA_WIDTH-1:0] mem_wdata;
   logic [DATA_WIDTH-1:0] mem_rdata;

   modport slave (
      input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
      output cpu_ack, cpu_rdata,
      input  aux_req, aux_we, aux_addr, aux_wdata,
      output aux_ack, aux_rdata,
      output mem_addr, mem_we, mem_wdata,
      input  mem_rdata
   );

   modport master (
      output cpu_req, cpu_we, cpu_addr, cpu_wdata,
      input  cpu_ack, cpu_rdata,
      output aux_req, aux_we, aux_addr, aux_wdata,
      input  aux_ack, aux_rdata,
      input  mem_addr, mem_we, mem_wdata,
      output mem_rdata
   );

endinterface

// File: rtl/rr_arbiter2.sv
// Two-way round-robin pick; one requester may be masked out (the one being acked).
module rr_arbiter2
   import mem_arb_pkg::*;
(
   input  logic [1:0] req,
   input  logic       last_gnt,
   input  logic       excl_vld,
   input  logic       excl_id,
   output logic       valid,
   output logic       gnt_id
);

   logic [1:0] elig;

   always_comb begin
      elig = req;
      if (excl_vld) begin
         if (excl_id == GNT_AUX) elig[1] = 1'b0;
         else                    elig[0] = 1'b0;
      end
      valid  = |elig;
      gnt_id = GNT_CPU;
      unique case (elig)
         2'b01:   gnt_id = GNT_CPU;
         2'b10:   gnt_id = GNT_AUX;
         2'b11:   gnt_id = ~last_gnt;
         default: gnt_id = GNT_CPU;
      endcase
   end

endmodule

// File: rtl/mem_arbiter.sv
// CPU/AUX round-robin arbiter for the single-port data memory:
// IDLE -> ISSUE (memory cycle) -> RESP (ack), with RESP->ISSUE interleave.
module mem_arbiter
   import mem_arb_pkg::*;
(
   input  logic          clk,
   input  logic          rst,
   mem_arbiter_if.slave  bus,
   output logic          busy,
   output logic          gnt
);

   state_e                state_q, state_d;
   logic                  gnt_q, gnt_d;
   logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
   logic                  mem_we_q, mem_we_d;
   logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;

   logic pick_vld;
   logic pick_id;

   // While acking, the current grantee still holds req and must not win again.
   rr_arbiter2 u_pick (
      .req      ({bus.aux_req, bus.cpu_req}),
      .last_gnt (gnt_q),
      .excl_vld (state_q == RESP),
      .excl_id  (gnt_q),
      .valid    (pick_vld),
      .gnt_id   (pick_id)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         gnt_q       <= GNT_AUX;
         mem_addr_q  <= '0;
         mem_we_q    <= 1'b0;
         mem_wdata_q <= '0;
      end else begin
         state_q     <= state_d;
         gnt_q       <= gnt_d;
         mem_addr_q  <= mem_addr_d;
         mem_we_q    <= mem_we_d;
         mem_wdata_q <= mem_wdata_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      gnt_d       = gnt_q;
      mem_addr_d  = mem_addr_q;
      mem_we_d    = 1'b0;
      mem_wdata_d = mem_wdata_q;
      unique case (state_q)
         IDLE, RESP: begin
            state_d = IDLE;
            if (pick_vld) begin
               state_d = ISSUE;
               gnt_d   = pick_id;
               if (pick_id == GNT_AUX) begin
                  mem_addr_d  = bus.aux_addr;
                  mem_we_d    = bus.aux_we;
                  mem_wdata_d = bus.aux_wdata;
               end else begin
                  mem_addr_d  = bus.cpu_addr;
                  mem_we_d    = bus.cpu_we;
                  mem_wdata_d = bus.cpu_wdata;
               end
            end
         end
         ISSUE:   state_d = RESP;
         default: state_d = IDLE;
      endcase
   end

   assign bus.cpu_ack   = (state_q == RESP) && (gnt_q == GNT_CPU);
   assign bus.aux_ack   = (state_q == RESP) && (gnt_q == GNT_AUX);
   assign bus.cpu_rdata = bus.mem_rdata;
   assign bus.aux_rdata = bus.mem_rdata;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_we    = mem_we_q;
   assign bus.mem_wdata = mem_wdata_q;
   assign busy          = (state_q != IDLE);
   assign gnt           = gnt_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed plus random stimulus against a cycle-count transaction model.
module tb_mem_arbiter;
   import mem_arb_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   mem_arbiter_if bif ();
   logic busy, gnt;

   mem_arbiter dut (
      .clk  (clk),
      .rst  (rst),
      .bus  (bif),
      .busy (busy),
      .gnt  (gnt)
   );

   // memory environment
   logic [15:0] tbmem [64];
   int          wr_cnt = 0;
   logic        pre_en;
   logic [5:0]  pre_addr;
   logic [15:0] pre_data;

   always @(posedge clk) begin
      if (pre_en) tbmem[pre_addr] <= pre_data;
      else if (bif.mem_we) begin
         tbmem[bif.mem_addr] <= bif.mem_wdata;
         wr_cnt <= wr_cnt + 1;
      end
      bif.mem_rdata <= tbmem[bif.mem_addr];
   end

   // reference model: one transaction in flight, acked two cycles after grant
   logic [15:0] ref_mem [64];
   int          cyc = 0;
   bit          m_busy = 0;
   bit          m_own = 0;
   int          m_due = 0;
   bit          m_last = 1;
   bit          m_we = 0;
   logic [5:0]  m_addr = '0;
   logic [15:0] m_wd = '0;
   bit          done [2];

   int          nerr = 0;
   int          nchk = 0;
   int          ack_who [$];
   int          ack_at [$];
   logic [15:0] cpu_rd_obs, aux_rd_obs;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      nchk++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic fail_now(input string tag);
      nchk++;
      nerr++;
      $error("FAIL %s: observed timeout expected completion", tag);
   endtask

   function automatic bit req_of(input bit w);
      return w ? bif.aux_req : bif.cpu_req;
   endfunction

   task automatic m_start(input bit w);
      m_busy = 1;
      m_own  = w;
      m_due  = cyc + 2;
      m_last = w;
      m_we   = w ? bif.aux_we : bif.cpu_we;
      m_addr = w ? bif.aux_addr : bif.cpu_addr;
      m_wd   = w ? bif.aux_wdata : bif.cpu_wdata;
   endtask

   task automatic drive(input bit w, input bit r, input bit we,
                        input logic [5:0] a, input logic [15:0] d);
      if (w) begin
         bif.aux_req = r; bif.aux_we = we;
         bif.aux_addr = a; bif.aux_wdata = d;
      end else begin
         bif.cpu_req = r; bif.cpu_we = we;
         bif.cpu_addr = a; bif.cpu_wdata = d;
      end
   endtask

   task automatic tick();
      bit iss, rsp;
      @(negedge clk);
      iss = m_busy && (m_due == cyc + 1);
      rsp = m_busy && (m_due == cyc);
      chk("busy", busy, m_busy);
      chk("gnt", gnt, m_last);
      chk("mem_we", bif.mem_we, iss && m_we);
      if (iss) begin
         chk("mem_addr", bif.mem_addr, m_addr);
         if (m_we) chk("mem_wdata", bif.mem_wdata, m_wd);
      end
      chk("cpu_ack", bif.cpu_ack, rsp && !m_own);
      chk("aux_ack", bif.aux_ack, rsp && m_own);
      if (rsp && !m_we)
         chk(m_own ? "aux_rdata" : "cpu_rdata",
             m_own ? bif.aux_rdata : bif.cpu_rdata, ref_mem[m_addr]);
      if (bif.cpu_ack === 1'b1) begin
         ack_who.push_back(0); ack_at.push_back(cyc);
         cpu_rd_obs = bif.cpu_rdata;
      end
      if (bif.aux_ack === 1'b1) begin
         ack_who.push_back(1); ack_at.push_back(cyc);
         aux_rd_obs = bif.aux_rdata;
      end
      done[0] = 0;
      done[1] = 0;
      if (rsp) begin
         if (m_we) ref_mem[m_addr] = m_wd;
         done[m_own] = 1;
         m_busy = 0;
         if (req_of(!m_own)) m_start(!m_own);
      end else if (!m_busy) begin
         if (bif.cpu_req && bif.aux_req) m_start(!m_last);
         else if (bif.cpu_req)           m_start(0);
         else if (bif.aux_req)           m_start(1);
      end
      cyc++;
      @(posedge clk);
      #1;
   endtask

   task automatic wait_done(input bit w, input int bound, input string tag);
      int n = 0;
      do begin
         tick();
         n++;
      end while (!done[w] && n < bound);
      if (!done[w]) fail_now(tag);
   endtask

   task automatic drain();
      int n = 0;
      forever begin
         if (done[0]) bif.cpu_req = 0;
         if (done[1]) bif.aux_req = 0;
         if (!bif.cpu_req && !bif.aux_req && !m_busy) break;
         if (n == 20) begin
            fail_now("drain");
            bif.cpu_req = 0;
            bif.aux_req = 0;
            break;
         end
         tick();
         n++;
      end
   endtask

   initial begin
      int n0, w0, k, nacks;
      drive(0, 0, 0, '0, '0);
      drive(1, 0, 0, '0, '0);
      pre_en = 1;
      cpu_rd_obs = '0;
      aux_rd_obs = '0;
      for (int a = 0; a < 64; a++) begin
         pre_addr = 6'(a);
         pre_data = 16'($urandom);
         if (a == 8) pre_data = 16'h1234;
         if (a == 5) pre_data = 16'h5555;
         ref_mem[a] = pre_data;
         @(posedge clk);
         #1;
      end
      pre_en = 0;

      chk("rst_mem_we", bif.mem_we, 0);
      chk("rst_mem_addr", bif.mem_addr, 0);
      chk("rst_mem_wdata", bif.mem_wdata, 0);
      chk("rst_busy", busy, 0);
      chk("rst_gnt", gnt, 1);
      chk("rst_cpu_ack", bif.cpu_ack, 0);
      chk("rst_aux_ack", bif.aux_ack, 0);
      rst = 0;

      // reset lands in the ISSUE cycle of a CPU write to address 5
      drive(0, 1, 1, 6'd5, 16'hAAAA);
      tick();
      chk("issue_we_before_rst", bif.mem_we, 1);
      w0 = wr_cnt;
      #2 rst = 1;
      #1;
      chk("midrst_mem_we", bif.mem_we, 0);
      chk("midrst_busy", busy, 0);
      chk("midrst_gnt", gnt, 1);
      chk("midrst_cpu_ack", bif.cpu_ack, 0);
      chk("midrst_mem_addr", bif.mem_addr, 0);
      drive(0, 0, 0, '0, '0);
      m_busy = 0;
      m_last = 1;
      @(posedge clk);
      @(negedge clk);
      chk("rst_hold_cpu_ack", bif.cpu_ack, 0);
      @(posedge clk);
      #1 rst = 0;
      chk("rst_write_lost_cnt", wr_cnt, w0);
      chk("rst_write_lost_mem", tbmem[5], 16'h5555);
      repeat (2) tick();

      // tie straight after reset: CPU first, AUX back-to-back
      ack_who.delete(); ack_at.delete();
      drive(0, 1, 0, 6'd8, '0);
      drive(1, 1, 0, 6'd9, '0);
      n0 = cyc;
      repeat (5) begin
         tick();
         if (done[0]) bif.cpu_req = 0;
         if (done[1]) bif.aux_req = 0;
      end
      drain();
      if (ack_who.size() >= 2) begin
         chk("tie_first_who", ack_who[0], 0);
         chk("tie_first_at", ack_at[0] - n0, 2);
         chk("tie_second_who", ack_who[1], 1);
         chk("tie_second_at", ack_at[1] - n0, 4);
      end else fail_now("tie_ack_count");

      // fairness: both masters re-request immediately after every ack
      ack_who.delete(); ack_at.delete();
      drive(0, 1, 0, 6'($urandom), '0);
      drive(1, 1, 0, 6'($urandom), '0);
      nacks = 0;
      k = 0;
      while (nacks < 8 && k < 40) begin
         tick();
         k++;
         for (int i = 0; i < 2; i++)
            if (done[i]) begin
               nacks++;
               drive(i[0], 1, 0, 6'($urandom), '0);
            end
      end
      drain();
      if (ack_who.size() >= 8) begin
         for (int i = 0; i < 8; i++) begin
            chk("fair_order", ack_who[i], i % 2);
            if (i > 0) chk("fair_spacing", ack_at[i] - ack_at[i-1], 2);
         end
      end else fail_now("fair_ack_count");

      // CPU read of a preloaded word
      ack_who.delete(); ack_at.delete();
      drive(0, 1, 0, 6'd8, '0);
      n0 = cyc;
      wait_done(0, 6, "cpu_read_timeout");
      drive(0, 0, 0, '0, '0);
      chk("cpu_read_data", cpu_rd_obs, 16'h1234);
      if (ack_at.size() >= 1) chk("cpu_read_lat", ack_at[0] - n0, 2);
      else fail_now("cpu_read_ack");

      // AUX write to the top address, then CPU reads it back
      ack_who.delete(); ack_at.delete();
      drive(1, 1, 1, 6'd63, 16'hBEEF);
      n0 = cyc;
      wait_done(1, 6, "aux_write_timeout");
      drive(1, 0, 0, '0, '0);
      if (ack_at.size() >= 1) begin
         chk("aux_write_lat", ack_at[0] - n0, 2);
         chk("aux_write_who", ack_who[0], 1);
      end else fail_now("aux_write_ack");
      drive(0, 1, 0, 6'd63, '0);
      wait_done(0, 6, "cpu_read63_timeout");
      drive(0, 0, 0, '0, '0);
      chk("cpu_read63_data", cpu_rd_obs, 16'hBEEF);
      drive(0, 1, 0, 6'd5, '0);
      wait_done(0, 6, "cpu_read5_timeout");
      drive(0, 0, 0, '0, '0);
      chk("cpu_read5_data", cpu_rd_obs, 16'h5555);

      // CPU drops req during ISSUE: one ack, one write
      ack_who.delete(); ack_at.delete();
      w0 = wr_cnt;
      drive(0, 1, 1, 6'd20, 16'h7777);
      tick();
      drive(0, 0, 0, '0, '0);
      repeat (3) tick();
      chk("abuse_writes", wr_cnt - w0, 1);
      chk("abuse_acks", ack_who.size(), 1);
      chk("abuse_mem", tbmem[20], 16'h7777);

      // random traffic
      for (int it = 0; it < 400; it++) begin
         for (int i = 0; i < 2; i++) begin
            if (done[i]) drive(i[0], 0, 0, '0, '0);
            if (!req_of(i[0]) && $urandom_range(0, 2) == 0)
               drive(i[0], 1, 1'($urandom),
                     ($urandom_range(0, 1) == 0) ? 6'($urandom_range(0, 7))
                                                 : 6'($urandom),
                     16'($urandom));
         end
         tick();
      end
      drain();
      repeat (2) tick();

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester round-robin arbiter sharing the single-port synchronous data memory (16-bit words, 64 addresses) between the CPU and an auxiliary master (program loader / debug port). It sits between the CPU memory interface and the memory. It sequences each access through a fixed issue/response pipeline with one-cycle memory read latency and returns a one-cycle acknowledge to the granted requester.

## Interface
- DATA_WIDTH, 16, memory word width
- ADDR_WIDTH, 6, memory address width
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- cpu_req  in  1  CPU access request; held with cpu_we/addr/wdata stable until cpu_ack
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  ADDR_WIDTH  CPU word address
- cpu_wdata  in  DATA_WIDTH  CPU write data
- cpu_ack  out  1  one-cycle completion pulse
- cpu_rdata  out  DATA_WIDTH  read data, valid only while cpu_ack=1
- aux_req, aux_we, aux_addr, aux_wdata, aux_ack, aux_rdata: same as cpu_* for the auxiliary master
- mem_addr  out  ADDR_WIDTH  memory address (registered)
- mem_we  out  1  memory write enable (registered)
- mem_wdata  out  DATA_WIDTH  memory write data (registered)
- mem_rdata  in  DATA_WIDTH  memory read data, valid the cycle after address presented
- busy  out  1  1 in ISSUE or RESP
- gnt  out  1  current/last grantee: 0 = CPU, 1 = AUX

## Operation
- States: IDLE, ISSUE, RESP.
- IDLE: if any req, pick grantee (see arbitration), register its addr/we/wdata onto mem_*, set gnt, go ISSUE; else stay, mem_we=0.
- ISSUE: memory sees mem_addr/mem_we/mem_wdata; write is captured at the closing edge, read data appears on mem_rdata next cycle. Go RESP.
- RESP: assert grantee's ack for exactly one cycle; mem_we=0. The grantee's own req is ignored this cycle (it is still high by protocol). If the other requester's req=1, latch it and go ISSUE (back-to-back interleave); else go IDLE.
- Arbitration: single requester wins. Both requesting in IDLE: grant the one that did not win last (last_gnt register, reset = AUX, so CPU wins first tie).
- cpu_rdata and aux_rdata are both driven from mem_rdata; meaningful only with their ack. For writes rdata is don't-care.
- Requester protocol: drop req or present a new request in the cycle after ack. A new request held in that cycle is accepted from IDLE next.
- req dropped before ack: illegal. The in-flight transaction still completes and ack still pulses.
- Address/data wrap: none. The address is passed through unmodified; all ADDR_WIDTH bits are used.

## Timing
- Reset (async, immediate): state=IDLE, mem_addr=0, mem_we=0, mem_wdata=0, cpu_ack=0, aux_ack=0, busy=0, gnt=1 (last_gnt=AUX).
- Reset mid-transaction: mem_we drops immediately. A write not yet captured by the memory is lost. No ack is issued after reset.
- Latency: req high in cycle N (IDLE) -> mem_* valid in N+1 -> ack in N+2.
- Isolated requester throughput: one access per 3 cycles.
- Alternating requesters: one access per 2 cycles via RESP->ISSUE.
- ack is never asserted to both requesters in the same cycle. Ack never occurs without a preceding grant.

## Structure
- Package mem_arb_pkg: state encoding (IDLE/ISSUE/RESP, 2 bits) and grantee constants GNT_CPU=0, GNT_AUX=1.
- Sub-module rr_arbiter2: inputs req[1:0], last_gnt, exclude-valid/exclude-id. Outputs valid and gnt id. It is purely the pick logic; the FSM and registers stay in mem_arbiter.

## Test plan
- Reset: assert rst mid-ISSUE of a write to addr 5 -> mem_we=0 immediately, state IDLE, no ack, gnt=1.
- CPU read: mem[8]=16'h1234, cpu_req/addr=8 in cycle N -> mem_addr=8 at N+1, cpu_ack=1 with cpu_rdata=16'h1234 at N+2, aux_ack=0.
- AUX write then CPU read: aux writes 16'hBEEF to addr 63 -> aux_ack at N+2. CPU then reads addr 63 -> 16'hBEEF.
- Tie: cpu_req and aux_req both rise in the same cycle after reset -> CPU acked first at N+2, AUX acked at N+4 (back-to-back via RESP->ISSUE).
- Fairness: both requesters continuously re-request for 8 transactions -> acks strictly alternate CPU, AUX, ... with a 2-cycle spacing.
- Protocol abuse: cpu_req dropped in ISSUE -> cpu_ack still pulses once at RESP, then IDLE. No duplicate memory write.
